conv_host_mem: RTL

- Responder side of the convolution engine's memory protocol.
- Holds the 64x64 input image and serves it on iaddr/idata.
- Raises the ready handshake, and holds the layer-0 (4096x20) and layer-1 (1024x20) result memories addressed by csel, answering cwr/crd traffic.
- After the engine drops busy, streams stored results out on a valid/ready dump port for checking or downstream use.

---
 rtl/conv_host_mem.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_host_mem.sv
// conv_host_mem: responder side of the convolution engine memory protocol.
// Holds the 64x64 input image (iaddr/idata) and the layer-0 (4096 words) and
// layer-1 (1024 words) result memories (csel/cwr/crd). It raises ready once the
// image is loaded. After busy falls it streams results out on the dump port.
// Ports:
//   clk, reset (async, active low)
//   img_wr/img_addr/img_data/img_last  image load, accepted only in LOAD
//   ready, busy                        handshake with the engine
//   iaddr -> idata                     combinational image read
//   cwr/caddr_wr/cdata_wr              result write; csel selects the memory
//   crd/caddr_rd -> cdata_rd           combinational result read
//   dump_valid/dump_ready/dump_layer/dump_addr/dump_data  result stream
//   done                               sticky end-of-dump flag
module conv_host_mem #(
    parameter int unsigned DW      = 20,
    parameter int unsigned DUMP_L0 = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          img_wr,
    input  logic [11:0]   img_addr,
    input  logic [DW-1:0] img_data,
    input  logic          img_last,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic          dump_layer,
    output logic [11:0]   dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          done
);
    localparam int unsigned AW        = 12;
    localparam int unsigned L1_AW     = 10;
    localparam int unsigned IMG_DEPTH = 4096;
    localparam int unsigned L0_DEPTH  = 4096;
    localparam int unsigned L1_DEPTH  = 1024;
    localparam logic [AW-1:0] L0_LAST = AW'(L0_DEPTH - 1);
    localparam logic [AW-1:0] L1_LAST = AW'(L1_DEPTH - 1);
    localparam logic [2:0]    SEL_L0  = 3'b001;
    localparam logic [2:0]    SEL_L1  = 3'b011;

    typedef enum logic [2:0] {
        S_LOAD, S_READY, S_RUN, S_DUMP, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0_mem  [L0_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    logic          busy_q;
    logic          ready_nx, done_nx, valid_nx, layer_nx, load_nx;
    logic [AW-1:0] addr_nx;

    // crd carries no timing meaning: read data is driven regardless
    logic unused_crd;
    assign unused_crd = crd;

    logic fall_c, xfer_c, at_end_c;
    assign fall_c   = busy_q & ~busy;
    assign xfer_c   = dump_valid & dump_ready;
    assign at_end_c = dump_layer & (dump_addr == L1_LAST);

    // Combinational reads; the 12-bit image address wraps naturally
    assign idata = img_mem[iaddr];

    always_comb begin : rd_mux
        cdata_rd = '0;
        if (csel == SEL_L0) begin
            cdata_rd = l0_mem[caddr_rd];
        end else if (csel == SEL_L1) begin
            cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
        end
    end

    // Memory writes; contents are not reset
    always_ff @(posedge clk) begin : mem_wr
        if (img_wr && (state == S_LOAD)) begin
            img_mem[img_addr] <= img_data;
        end
        if (cwr && (csel == SEL_L0)) begin
            l0_mem[caddr_wr] <= cdata_wr;
        end
        if (cwr && (csel == SEL_L1)) begin
            l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_nx = state;
        case (state)
            S_LOAD:  if (img_wr && img_last) state_nx = S_READY;
            S_READY: if (busy)               state_nx = S_RUN;
            S_RUN:   if (fall_c)             state_nx = S_DUMP;
            S_DUMP:  if (xfer_c && at_end_c) state_nx = S_DONE;
            S_DONE:                          state_nx = S_DONE;
            default:                         state_nx = S_LOAD;
        endcase
    end

    // Next values of the registered outputs and the dump pointer
    always_comb begin : output_nx
        ready_nx = (state_nx == S_READY);
        done_nx  = (state_nx == S_DONE);
        valid_nx = dump_valid;
        layer_nx = dump_layer;
        addr_nx  = dump_addr;
        load_nx  = 1'b0;
        case (state)
            S_RUN: begin
                if (fall_c) begin
                    valid_nx = 1'b1;
                    layer_nx = (DUMP_L0 == 0);
                    addr_nx  = '0;
                    load_nx  = 1'b1;
                end
            end
            S_DUMP: begin
                if (xfer_c) begin
                    if (at_end_c) begin
                        valid_nx = 1'b0;
                    end else if (!dump_layer && (dump_addr == L0_LAST)) begin
                        layer_nx = 1'b1;
                        addr_nx  = '0;
                        load_nx  = 1'b1;
                    end else begin
                        addr_nx  = dump_addr + AW'(1);
                        load_nx  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers; dump_data samples memory when the pointer moves,
    // so it stays frozen across stalls
    always_ff @(posedge clk or negedge reset) begin : out_reg
        if (!reset) begin
            busy_q     <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            dump_layer <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            busy_q     <= busy;
            ready      <= ready_nx;
            done       <= done_nx;
            dump_valid <= valid_nx;
            dump_layer <= layer_nx;
            dump_addr  <= addr_nx;
            if (load_nx) begin
                dump_data <= layer_nx ? l1_mem[addr_nx[L1_AW-1:0]] : l0_mem[addr_nx];
            end
        end
    end
endmodule
